// File: rtl/vgm_sva_stim_player_pkg.sv
// Shared types for the SVA stimulus player.
// State encoding and default stimulus entry layout.
package vgm_sva_stim_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        FINISH
    } stim_state_e;

    localparam int STIM_WIDTH  = 8;
    localparam int STIM_HOLD_W = 8;

    typedef struct packed {
        logic [STIM_WIDTH-1:0]  value;
        logic [STIM_HOLD_W-1:0] hold;
    } stim_entry_t;

endpackage

// File: rtl/vgm_sva_stim_player_if.sv
// Load/control/stimulus bundle of the SVA stimulus player.
// master = test side, slave = player side.
interface vgm_sva_stim_player_if #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int HOLD_W = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              load_valid;
    logic              load_ready;
    logic [WIDTH-1:0]  load_value;
    logic [HOLD_W-1:0] load_hold;
    logic              start;
    logic              abort;
    logic [WIDTH-1:0]  sig_out;
    logic              sig_active;
    logic              busy;
    logic              done;
    logic [CW-1:0]     count;

    modport master (
        output load_valid, load_value, load_hold, start, abort,
        input  load_ready, sig_out, sig_active, busy, done, count
    );

    modport slave (
        input  load_valid, load_value, load_hold, start, abort,
        output load_ready, sig_out, sig_active, busy, done, count
    );

endinterface

// File: rtl/vgm_sva_stim_fifo.sv
// Synchronous FIFO of stimulus entries with flush.
// Pointers carry an extra MSB to tell full from empty.
module vgm_sva_stim_fifo
    import vgm_sva_stim_pkg::*;
#(
    parameter int  DEPTH   = 16,
    parameter type entry_t = stim_entry_t,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  entry_t      din,
    input  logic        pop,
    input  logic        flush,
    output entry_t      dout,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    entry_t      mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        push_ok;
    logic        pop_ok;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Storage array; contents need no reset, pointers gate validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointer advance; flush empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vgm_sva_stim_player.sv
// Plays back queued (value, hold) entries onto a stimulus bus.
// Each entry is driven for hold+1 cycles, then done pulses once.
module vgm_sva_stim_player
    import vgm_sva_stim_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               DEPTH      = 16,
    parameter int               HOLD_W     = 8,
    parameter logic [WIDTH-1:0] IDLE_VALUE = '0
) (
    input logic                  clk,
    input logic                  rst,
    vgm_sva_stim_player_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [WIDTH-1:0]  value;
        logic [HOLD_W-1:0] hold;
    } entry_t;

    stim_state_e       state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [WIDTH-1:0]  sig_out_q;
    logic              sig_active_q;
    logic              busy_q;
    logic              done_q;

    entry_t            push_entry;
    entry_t            head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              push;
    logic              pop;
    logic              start_go;
    logic              next_go;

    assign push_entry = '{value: bus.load_value, hold: bus.load_hold};

    assign bus.load_ready = (state == IDLE) && !fifo_full &&
                            !bus.start && !bus.abort;

    assign push     = bus.load_valid && bus.load_ready;
    assign start_go = (state == IDLE) && bus.start && !bus.abort;
    assign next_go  = (state == PLAY) && (hold_cnt == '0) && !bus.abort;
    assign pop      = (start_go || next_go) && !fifo_empty;

    vgm_sva_stim_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .flush (bus.abort),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Playback FSM with hold counter and registered stimulus outputs.
    always_ff @(posedge clk) begin
        if (rst || bus.abort) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            sig_out_q    <= IDLE_VALUE;
            sig_active_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        if (!fifo_empty) begin
                            state        <= PLAY;
                            sig_out_q    <= head.value;
                            hold_cnt     <= head.hold;
                            sig_active_q <= 1'b1;
                            busy_q       <= 1'b1;
                        end else begin
                            state  <= FINISH;
                            done_q <= 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end else if (!fifo_empty) begin
                        sig_out_q <= head.value;
                        hold_cnt  <= head.hold;
                    end else begin
                        state        <= FINISH;
                        sig_out_q    <= IDLE_VALUE;
                        sig_active_q <= 1'b0;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                    end
                end
                FINISH: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.sig_out    = sig_out_q;
    assign bus.sig_active = sig_active_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.count      = fifo_count;

endmodule

// File: tb/tb_vgm_sva_stim_player.sv
// Directed bench for vgm_sva_stim_player.
// Vector table plus hand-written multi-cycle sequences.
module tb_vgm_sva_stim_player;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    vgm_sva_stim_player_if #(.WIDTH(8), .DEPTH(16), .HOLD_W(8)) bus ();

    vgm_sva_stim_player dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       lv;
        logic       st;
        logic       ab;
        logic [7:0] v;
        logic [7:0] h;
        logic [7:0] e_out;
        logic       e_act;
        logic       e_busy;
        logic       e_done;
        logic [4:0] e_cnt;
        logic       e_rdy;
    } vec_t;

    vec_t tbl [18];
    logic [7:0] exp_v [16];
    logic [7:0] exp_h [16];

    function automatic vec_t mk(logic lv, logic st, logic ab,
                                logic [7:0] v, logic [7:0] h,
                                logic [7:0] eo, logic ea, logic eb,
                                logic ed, logic [4:0] ec, logic er);
        vec_t r;
        r.lv = lv; r.st = st; r.ab = ab; r.v = v; r.h = h;
        r.e_out = eo; r.e_act = ea; r.e_busy = eb;
        r.e_done = ed; r.e_cnt = ec; r.e_rdy = er;
        return r;
    endfunction

    task automatic chk(string name, int act, int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        bus.load_valid = 1'b0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.load_value = '0;
        bus.load_hold  = '0;
    endtask

    task automatic chk_idle_outs(string tag);
        chk({tag, ".sig_out"}, int'(bus.sig_out), 0);
        chk({tag, ".sig_active"}, int'(bus.sig_active), 0);
        chk({tag, ".busy"}, int'(bus.busy), 0);
    endtask

    // Plays n entries from exp_v/exp_h; start must be high in this cycle.
    task automatic play_check(string tag, int n);
        for (int e = 0; e < n; e++) begin
            for (int c = 0; c <= int'(exp_h[e]); c++) begin
                tick();
                bus.start = 1'b0;
                #1;
                if (bus.sig_out !== exp_v[e] || bus.sig_active !== 1'b1 ||
                    bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                    chk({tag, ".entry"}, int'({bus.sig_active, bus.busy,
                        bus.done, bus.sig_out}), int'({3'b110, exp_v[e]}));
                end else begin
                    total++;
                end
            end
        end
        tick();
        #1;
        chk({tag, ".done"}, int'(bus.done), 1);
        chk({tag, ".busy_fall"}, int'(bus.busy), 0);
        chk({tag, ".count_end"}, int'(bus.count), 0);
    endtask

    initial begin
        int n_act;
        int fin_k;

        drive_idle();

        tbl[0]  = mk(1, 0, 0, 8'hA5, 8'd0, 8'h00, 0, 0, 0, 5'd0, 1);
        tbl[1]  = mk(1, 0, 0, 8'h3C, 8'd2, 8'h00, 0, 0, 0, 5'd1, 1);
        tbl[2]  = mk(1, 0, 0, 8'hFF, 8'd1, 8'h00, 0, 0, 0, 5'd2, 1);
        tbl[3]  = mk(0, 1, 0, 8'h00, 8'd0, 8'h00, 0, 0, 0, 5'd3, 0);
        tbl[4]  = mk(0, 0, 0, 8'h00, 8'd0, 8'hA5, 1, 1, 0, 5'd2, 0);
        tbl[5]  = mk(0, 0, 0, 8'h00, 8'd0, 8'h3C, 1, 1, 0, 5'd1, 0);
        tbl[6]  = mk(0, 0, 0, 8'h00, 8'd0, 8'h3C, 1, 1, 0, 5'd1, 0);
        tbl[7]  = mk(0, 0, 0, 8'h00, 8'd0, 8'h3C, 1, 1, 0, 5'd1, 0);
        tbl[8]  = mk(0, 0, 0, 8'h00, 8'd0, 8'hFF, 1, 1, 0, 5'd0, 0);
        tbl[9]  = mk(0, 0, 0, 8'h00, 8'd0, 8'hFF, 1, 1, 0, 5'd0, 0);
        tbl[10] = mk(0, 0, 0, 8'h00, 8'd0, 8'h00, 0, 0, 1, 5'd0, 0);
        tbl[11] = mk(0, 0, 0, 8'h00, 8'd0, 8'h00, 0, 0, 0, 5'd0, 1);
        tbl[12] = mk(0, 1, 0, 8'h00, 8'd0, 8'h00, 0, 0, 0, 5'd0, 0);
        tbl[13] = mk(0, 0, 0, 8'h00, 8'd0, 8'h00, 0, 0, 1, 5'd0, 0);
        tbl[14] = mk(0, 0, 0, 8'h00, 8'd0, 8'h00, 0, 0, 0, 5'd0, 1);
        tbl[15] = mk(1, 1, 0, 8'h11, 8'd0, 8'h00, 0, 0, 0, 5'd0, 0);
        tbl[16] = mk(0, 0, 0, 8'h00, 8'd0, 8'h00, 0, 0, 1, 5'd0, 0);
        tbl[17] = mk(0, 0, 0, 8'h00, 8'd0, 8'h00, 0, 0, 0, 5'd0, 1);

        // reset state
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_idle_outs("reset");
        chk("reset.done", int'(bus.done), 0);
        chk("reset.count", int'(bus.count), 0);
        chk("reset.load_ready", int'(bus.load_ready), 1);

        // reset mid-load
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.load_valid = 1'b1;
            bus.load_value = 8'h40 + 8'(i);
            bus.load_hold  = 8'd1;
        end
        tick();
        drive_idle();
        rst = 1'b1;
        #1;
        chk("midload.count_before", int'(bus.count), 3);
        tick();
        rst = 1'b0;
        #1;
        chk("midload.count", int'(bus.count), 0);
        chk_idle_outs("midload");
        chk("midload.load_ready", int'(bus.load_ready), 1);

        // table: basic playback, empty start, start+load collision
        for (int i = 0; i < 18; i++) begin
            tick();
            bus.load_valid = tbl[i].lv;
            bus.start      = tbl[i].st;
            bus.abort      = tbl[i].ab;
            bus.load_value = tbl[i].v;
            bus.load_hold  = tbl[i].h;
            #1;
            chk($sformatf("tbl%0d.sig_out", i), int'(bus.sig_out), int'(tbl[i].e_out));
            chk($sformatf("tbl%0d.sig_active", i), int'(bus.sig_active), int'(tbl[i].e_act));
            chk($sformatf("tbl%0d.busy", i), int'(bus.busy), int'(tbl[i].e_busy));
            chk($sformatf("tbl%0d.done", i), int'(bus.done), int'(tbl[i].e_done));
            chk($sformatf("tbl%0d.count", i), int'(bus.count), int'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d.load_ready", i), int'(bus.load_ready), int'(tbl[i].e_rdy));
        end
        tick();
        drive_idle();

        // full FIFO, rejected 17th, wrap across two fills
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 16; i++) begin
                exp_v[i] = (b == 0) ? 8'h10 + 8'(i) : 8'h80 + 8'(i);
                exp_h[i] = (b == 0) ? 8'(i % 3) : 8'((i + 1) % 4);
                tick();
                bus.load_valid = 1'b1;
                bus.load_value = exp_v[i];
                bus.load_hold  = exp_h[i];
            end
            tick();
            bus.load_value = 8'hEE;
            bus.load_hold  = 8'd0;
            #1;
            chk($sformatf("full%0d.count", b), int'(bus.count), 16);
            chk($sformatf("full%0d.load_ready", b), int'(bus.load_ready), 0);
            tick();
            drive_idle();
            #1;
            chk($sformatf("full%0d.count_17th", b), int'(bus.count), 16);
            tick();
            bus.start = 1'b1;
            play_check($sformatf("wrap%0d", b), 16);
            tick();
            drive_idle();
        end

        // abort mid-play
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.load_valid = 1'b1;
            bus.load_value = 8'h31 + 8'(i);
            bus.load_hold  = 8'd5;
        end
        tick();
        drive_idle();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        #1;
        chk("abort.first", int'(bus.sig_out), 'h31);
        tick();
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        #1;
        chk_idle_outs("abort");
        chk("abort.count", int'(bus.count), 0);
        chk("abort.done", int'(bus.done), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            chk($sformatf("abort.nodone%0d", k), int'(bus.done), 0);
        end

        // max hold: 256 cycles then done
        tick();
        bus.load_valid = 1'b1;
        bus.load_value = 8'h5A;
        bus.load_hold  = 8'hFF;
        tick();
        drive_idle();
        bus.start = 1'b1;
        n_act = 0;
        fin_k = -1;
        for (int k = 0; k < 300; k++) begin
            tick();
            bus.start = 1'b0;
            #1;
            if (bus.done === 1'b1) begin
                fin_k = k;
                break;
            end
            if (bus.sig_active === 1'b1 && bus.sig_out === 8'h5A) begin
                n_act++;
            end
        end
        chk("maxhold.cycles", n_act, 256);
        chk("maxhold.done_at", fin_k, 256);
        chk_idle_outs("maxhold.end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
